alu_exec_unit: RTL and testbench

//  Execute-stage ALU that consumes the 4-bit ALUControl code (control_pkg enum) and two operands.
//  It returns the result and a zero flag over a valid/ready handshake.

---
 rtl/alu_exec_unit.sv | 206 ++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU with a valid/ready handshake on both sides. Logic,
// arithmetic, compare and undefined ops complete in one cycle. Shifts are
// done one bit per cycle in the default build, so the unit holds in_ready low
// while a shift is in progress.
//
// Build option:
//   ALU_BARREL_SHIFT_EN  defined   -> shifts use a combinational barrel
//                                     shifter; every op has latency 1 and the
//                                     SHIFT state is never entered.
//                        undefined -> iterative 1-bit-per-cycle shifter.
//
// Ports:
//   clk        in   1     clock, all state on the rising edge
//   rst_n      in   1     asynchronous active-low reset
//   flush      in   1     synchronous abort of the in-flight op
//   in_valid   in   1     operands + op valid
//   in_ready   out  1     unit accepts an op this cycle
//   alu_ctrl   in   4     op code (see ALU_* below)
//   op_a       in   XLEN  operand A
//   op_b       in   XLEN  operand B; shift amount is op_b[$clog2(XLEN)-1:0]
//   out_valid  out  1     result valid
//   out_ready  in   1     consumer takes the result
//   result     out  XLEN  ALU result
//   zero       out  1     result == 0
//
// States:
//   state  | meaning
//   IDLE   | no result pending, ready for a new op
//   SHIFT  | iterative shift in progress, one bit per cycle
//   DONE   | result valid, held until out_ready
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

`ifdef ALU_BARREL_SHIFT_EN
    localparam bit ITER_SHIFT = 1'b0;
`else
    localparam bit ITER_SHIFT = 1'b1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;

    logic              accept;
    logic              is_shift;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   acc_step;

    assign shamt    = op_b[SHW-1:0];
    assign is_shift = (alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SRL) || (alu_ctrl == ALU_SRA);
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath. In the iterative build a shift only lands here
    // when shamt is zero, so the result is simply op_a.
    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
`else
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
`endif
            default:  alu_res = '0;
        endcase
    end

    // One bit of shift on the captured accumulator, using the captured op.
    always_comb begin
        acc_step = acc_q;
        case (op_q)
            ALU_SLL: acc_step = {acc_q[XLEN-2:0], 1'b0};
            ALU_SRL: acc_step = {1'b0, acc_q[XLEN-1:1]};
            ALU_SRA: acc_step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            default: acc_step = acc_q;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;

        if (flush) begin
            // Abort wins over everything; the last result stays visible on
            // the result port but out_valid drops.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        op_d = alu_ctrl;
                        if (ITER_SHIFT && is_shift && (shamt != '0)) begin
                            acc_d   = op_a;
                            cnt_d   = shamt;
                            state_d = ST_SHIFT;
                        end else begin
                            result_d = alu_res;
                            zero_d   = (alu_res == '0);
                            state_d  = ST_DONE;
                        end
                    end else if ((state_q == ST_DONE) && out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - SHW'(1);
                    // Last step: the shifted value goes straight to result so
                    // total latency is shamt + 1 cycles from accept.
                    if (cnt_q == SHW'(1)) begin
                        result_d = acc_step;
                        zero_d   = (acc_step == '0);
                        state_d  = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = (state_q == ST_DONE);
        result    = result_q;
        zero      = zero_q;
        if (!flush) begin
            in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    localparam logic [3:0] C_ADD  = 4'd0;
    localparam logic [3:0] C_SUB  = 4'd1;
    localparam logic [3:0] C_SLL  = 4'd2;
    localparam logic [3:0] C_SLT  = 4'd3;
    localparam logic [3:0] C_SLTU = 4'd4;
    localparam logic [3:0] C_XOR  = 4'd5;
    localparam logic [3:0] C_SRL  = 4'd6;
    localparam logic [3:0] C_SRA  = 4'd7;
    localparam logic [3:0] C_UNDEF = 4'd12;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int n_pass;
    int n_total;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input int sh);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        return (sh == 0) ? 1 : sh + 1;
`endif
    endfunction

    // Presents one op with out_ready=1, scrambles the inputs after accept, and
    // counts edges from the accept edge until out_valid (bounded at 100).
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int rdy_hi);
        alu_ctrl  = c;
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        alu_ctrl = C_ADD;
        op_a     = 32'h1234_5678;
        op_b     = 32'h0000_0003;
        lat      = 1;
        rdy_hi   = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_hi++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctrl = C_ADD; op_a = '0; op_b = '0;
        tick(); tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 00000000", result); else n_pass++;
        n_total++; if (zero !== 1'b1) $display("FAIL reset_zero: got %b want 1", zero); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        tick();
    endtask

    task automatic test_add_wrap();
        int lat, rh;
        issue(C_ADD, 32'hFFFF_FFFF, 32'h0000_0001, lat, rh);
        n_total++; if (lat !== 1) $display("FAIL add_latency: got %0d want 1", lat); else n_pass++;
        n_total++; if (result !== 32'h0) $display("FAIL add_result: got %h want 00000000", result); else n_pass++;
        n_total++; if (zero !== 1'b1) $display("FAIL add_zero: got %b want 1", zero); else n_pass++;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL add_drain: got out_valid %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ctl [3];
        logic [31:0] va  [3];
        logic [31:0] vb  [3];
        logic [31:0] exp [3];
        ctl[0] = C_SUB;  va[0] = 32'd5;         vb[0] = 32'd7; exp[0] = 32'hFFFF_FFFE;
        ctl[1] = C_SLT;  va[1] = 32'hFFFF_FFFF; vb[1] = 32'd1; exp[1] = 32'h0000_0001;
        ctl[2] = C_SLTU; va[2] = 32'hFFFF_FFFF; vb[2] = 32'd1; exp[2] = 32'h0000_0000;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_ctrl = ctl[i]; op_a = va[i]; op_b = vb[i]; in_valid = 1'b1;
            #1;
            n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); else n_pass++;
            tick();
            n_total++; if (out_valid !== 1'b1 || result !== exp[i])
                $display("FAIL b2b_result[%0d]: got valid %b result %h want valid 1 result %h", i, out_valid, result, exp[i]);
            else n_pass++;
            n_total++; if (zero !== (exp[i] == 32'h0)) $display("FAIL b2b_zero[%0d]: got %b want %b", i, zero, (exp[i] == 32'h0)); else n_pass++;
        end
        in_valid = 1'b0;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got out_valid %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_shift();
        logic [3:0]  ctl [6];
        logic [31:0] va  [6];
        logic [31:0] vb  [6];
        logic [31:0] exp [6];
        int lat, rh;
        ctl[0] = C_SRA; va[0] = 32'h8000_0000; vb[0] = 32'd4;  exp[0] = 32'hF800_0000;
        ctl[1] = C_SLL; va[1] = 32'h0000_0001; vb[1] = 32'd0;  exp[1] = 32'h0000_0001;
        ctl[2] = C_SRL; va[2] = 32'h8000_0000; vb[2] = 32'd31; exp[2] = 32'h0000_0001;
        ctl[3] = C_SLL; va[3] = 32'h0000_0001; vb[3] = 32'h21; exp[3] = 32'h0000_0002;
        ctl[4] = C_SLL; va[4] = 32'h8000_0000; vb[4] = 32'd1;  exp[4] = 32'h0000_0000;
        ctl[5] = C_SRA; va[5] = 32'h7000_0000; vb[5] = 32'd3;  exp[5] = 32'h0E00_0000;
        for (int i = 0; i < 6; i++) begin
            issue(ctl[i], va[i], vb[i], lat, rh);
            n_total++; if (lat !== exp_lat(int'(vb[i][4:0])))
                $display("FAIL shift_latency[%0d]: got %0d want %0d", i, lat, exp_lat(int'(vb[i][4:0])));
            else n_pass++;
            n_total++; if (rh !== 0) $display("FAIL shift_in_ready_busy[%0d]: got %0d ready cycles want 0", i, rh); else n_pass++;
            n_total++; if (result !== exp[i]) $display("FAIL shift_result[%0d]: got %h want %h", i, result, exp[i]); else n_pass++;
            n_total++; if (zero !== (exp[i] == 32'h0)) $display("FAIL shift_zero[%0d]: got %b want %b", i, zero, (exp[i] == 32'h0)); else n_pass++;
            tick();
        end
    endtask

    task automatic test_hold();
        alu_ctrl = C_XOR; op_a = 32'h0000_F0F0; op_b = 32'h0000_0FF0;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        // A competing op stays offered while the result is stalled.
        alu_ctrl = C_ADD; op_a = 32'd1; op_b = 32'd1;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (out_valid !== 1'b1 || result !== 32'h0000_FF00)
                $display("FAIL hold_result[%0d]: got valid %b result %h want valid 1 result 0000ff00", i, out_valid, result);
            else n_pass++;
            n_total++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); else n_pass++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL hold_release_ready: got %b want 1", in_ready); else n_pass++;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL hold_drain: got out_valid %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_undefined();
        int lat, rh;
        issue(C_UNDEF, 32'hDEAD_BEEF, 32'h1111_1111, lat, rh);
        n_total++; if (lat !== 1) $display("FAIL undef_latency: got %0d want 1", lat); else n_pass++;
        n_total++; if (result !== 32'h0 || zero !== 1'b1)
            $display("FAIL undef_result: got result %h zero %b want 00000000 1", result, zero);
        else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        int lat, rh;
        int seen;
        issue(C_ADD, 32'd3, 32'd4, lat, rh);
        n_total++; if (result !== 32'd7) $display("FAIL flush_setup: got %h want 00000007", result); else n_pass++;
        tick();
        // Flush with an op offered in IDLE: must not be accepted.
        flush = 1'b1; alu_ctrl = C_ADD; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL flush_idle_ready: got %b want 0", in_ready); else n_pass++;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b0 || result !== 32'd7)
            $display("FAIL flush_idle_no_accept: got valid %b result %h want 0 00000007", out_valid, result);
        else n_pass++;
        // Flush part way through a 10-bit shift.
        alu_ctrl = C_SRL; op_a = 32'hFFFF_FFFF; op_b = 32'd10; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL flush_shift_ready: got %b want 0", in_ready); else n_pass++;
        tick();
        flush = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL flush_idle_after: got in_ready %b want 1", in_ready); else n_pass++;
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            if (out_valid) seen++;
            tick();
        end
        n_total++; if (seen !== 0) $display("FAIL flush_no_valid: got %0d valid cycles want 0", seen); else n_pass++;
        n_total++; if (result !== 32'd7) $display("FAIL flush_result_kept: got %h want 00000007", result); else n_pass++;
    endtask

    task automatic test_reset_mid_shift();
        int lat, rh;
        alu_ctrl = C_SRL; op_a = 32'hFFFF_0000; op_b = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0 || result !== 32'h0)
            $display("FAIL rst_mid_shift: got valid %b result %h want 0 00000000", out_valid, result);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", in_ready); else n_pass++;
        seen_check: begin
            int seen;
            seen = 0;
            for (int i = 0; i < 25; i++) begin
                if (out_valid) seen++;
                tick();
            end
            n_total++; if (seen !== 0) $display("FAIL rst_no_stale_valid: got %0d valid cycles want 0", seen); else n_pass++;
        end
        issue(C_ADD, 32'd1, 32'd1, lat, rh);
        n_total++; if (lat !== 1 || result !== 32'd2)
            $display("FAIL rst_recover: got latency %0d result %h want 1 00000002", lat, result);
        else n_pass++;
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_add_wrap();
        test_back_to_back();
        test_shift();
        test_hold();
        test_undefined();
        test_flush();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
